// File: rtl/bus_master_tx.sv
// bus_master_tx: byte FIFO feeding a dValid/dAck bus master with a 4-beat timeout.
// Optional macro TX_RETRY_EN: a timed-out byte is resent once before err is raised.
module bus_master_tx #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       dValid,
    output logic [7:0] data,
    input  logic       dAck,
    output logic       tx_done,
    output logic       err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, VALID, GAP} state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_beat;
    logic [2:0]    w_beat_nxt;
    logic          r_dvalid;
    logic          w_dvalid_nxt;
    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic          r_tx_done;
    logic          w_tx_done_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
`ifdef TX_RETRY_EN
    logic          r_retry;
    logic          w_retry_nxt;
`endif

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // A pop in the same cycle never frees space for a write: in_ready alone gates pushes.
    assign in_ready = reset && !w_full;
    assign w_push   = in_valid && in_ready;

    assign dValid  = r_dvalid;
    assign data    = r_data;
    assign tx_done = r_tx_done;
    assign err     = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_dvalid  <= 1'b0;
            r_data    <= '0;
            r_tx_done <= 1'b0;
            r_err     <= 1'b0;
`ifdef TX_RETRY_EN
            r_retry   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_dvalid  <= w_dvalid_nxt;
            r_data    <= w_data_nxt;
            r_tx_done <= w_tx_done_nxt;
            r_err     <= w_err_nxt;
`ifdef TX_RETRY_EN
            r_retry   <= w_retry_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_dvalid_nxt  = r_dvalid;
        w_data_nxt    = r_data;
        w_tx_done_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_pop         = 1'b0;
`ifdef TX_RETRY_EN
        w_retry_nxt   = r_retry;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_data_nxt   = r_mem[r_rd_ptr];
                    w_dvalid_nxt = 1'b1;
                    w_beat_nxt   = 3'd1;
                    w_state_nxt  = VALID;
                end
            end
            VALID: begin
                // Ack on beat 1 is ignored so dValid always spans at least two cycles.
                if (dAck && (r_beat >= 3'd2)) begin
                    w_dvalid_nxt  = 1'b0;
                    w_tx_done_nxt = 1'b1;
                    w_state_nxt   = GAP;
`ifdef TX_RETRY_EN
                    w_retry_nxt   = 1'b0;
`endif
                end else if (r_beat == 3'd4) begin
                    w_dvalid_nxt = 1'b0;
                    w_state_nxt  = GAP;
`ifdef TX_RETRY_EN
                    if (r_retry) begin
                        w_err_nxt   = 1'b1;
                        w_retry_nxt = 1'b0;
                    end else begin
                        w_retry_nxt = 1'b1;
                    end
`else
                    w_err_nxt    = 1'b1;
`endif
                end else begin
                    w_beat_nxt = r_beat + 3'd1;
                end
            end
            GAP: begin
`ifdef TX_RETRY_EN
                if (r_retry) begin
                    w_dvalid_nxt = 1'b1;
                    w_beat_nxt   = 3'd1;
                    w_state_nxt  = VALID;
                end else begin
                    w_state_nxt = IDLE;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_master_tx.sv
// Self-checking bench for bus_master_tx: directed scenarios plus random traffic
// compared every cycle against a queue-based transfer model.
module tb_bus_master_tx;
    localparam int unsigned DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       dAck     = 1'b0;
    logic       in_ready;
    logic       dValid;
    logic [7:0] data;
    logic       tx_done;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_master_tx #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .dValid   (dValid),
        .data     (data),
        .dAck     (dAck),
        .tx_done  (tx_done),
        .err      (err)
    );

    // Model: pending bytes, and how long the current byte has been on the bus.
    logic [7:0] m_q[$];
    bit         m_dv;
    logic [7:0] m_data;
    int         m_hi;
    bit         m_gap;
    bit         m_done;
    bit         m_err;
    bit         m_retry;

    // Observations of the DUT for scenario-level literal checks.
    int         o_hi;
    int         o_done;
    int         o_err;
    logic [7:0] o_sent[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_obs();
        o_hi = 0;
        o_done = 0;
        o_err = 0;
        o_sent.delete();
    endtask

    task automatic model_step();
        bit full;
        full = (m_q.size() >= DEPTH);
        if (!reset) begin
            m_q.delete();
            m_dv = 0; m_data = 8'h00; m_hi = 0; m_gap = 0;
            m_done = 0; m_err = 0; m_retry = 0;
            return;
        end
        m_done = 0;
        m_err = 0;
        if (m_dv) begin
            if (dAck && m_hi >= 2) begin
                m_dv = 0; m_done = 1; m_retry = 0; m_gap = 1;
            end else if (m_hi == 4) begin
                m_dv = 0; m_gap = 1;
`ifdef TX_RETRY_EN
                if (!m_retry) m_retry = 1;
                else begin m_err = 1; m_retry = 0; end
`else
                m_err = 1;
`endif
            end else begin
                m_hi++;
            end
        end else if (m_gap) begin
            m_gap = 0;
            if (m_retry) begin m_dv = 1; m_hi = 1; end
        end else if (m_q.size() > 0) begin
            m_data = m_q.pop_front();
            m_dv = 1;
            m_hi = 1;
        end
        if (in_valid && !full) m_q.push_back(in_data);
    endtask

    task automatic compare();
        check("in_ready", in_ready, (reset && (m_q.size() < DEPTH)));
        check("dValid", dValid, m_dv);
        check("data", data, m_data);
        check("tx_done", tx_done, m_done);
        check("err", err, m_err);
        check("done_err_excl", tx_done && err, 0);
        if (dValid) o_hi++;
        if (tx_done) begin o_done++; o_sent.push_back(data); end
        if (err) o_err++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic xfer(input logic [7:0] b, input logic [3:0] mask, input int drain);
        int n;
        in_valid = 1; in_data = b; dAck = 0;
        cycle();
        in_valid = 0;
        n = 0;
        while (!dValid && n < 10) begin cycle(); n++; end
        check("dv_start", dValid, 1);
        for (int i = 0; i < 4; i++) begin
            dAck = mask[i];
            cycle();
            if (!dValid) break;
        end
        dAck = 0;
        repeat (drain) cycle();
    endtask

    initial begin
        logic [7:0] pay [6];
        int idx;
        int refused;
        bit full_seen;

        repeat (3) cycle();
        check("rst_dValid", dValid, 0);
        check("rst_data", data, 8'h00);
        check("rst_in_ready", in_ready, 0);
        reset = 1;
        cycle();

        // Ack on beat 2
        clear_obs();
        xfer(8'hA5, 4'b0010, 6);
        check("a5_hi", o_hi, 2);
        check("a5_done", o_done, 1);
        check("a5_err", o_err, 0);
        check("a5_byte", o_sent.size() > 0 ? o_sent[0] : 8'hxx, 8'hA5);

        // Ack on beats 1 and 3; the first is ignored
        clear_obs();
        xfer(8'h3C, 4'b0101, 6);
        check("3c_hi", o_hi, 3);
        check("3c_done", o_done, 1);
        check("3c_err", o_err, 0);

        // Never acked
        clear_obs();
        xfer(8'h77, 4'b0000, 12);
`ifdef TX_RETRY_EN
        check("77_hi", o_hi, 8);
`else
        check("77_hi", o_hi, 4);
`endif
        check("77_err", o_err, 1);
        check("77_done", o_done, 0);

        // Fill the FIFO while the first byte stalls, then ack everything
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        clear_obs();
        idx = 0; refused = 0; full_seen = 0;
        for (int k = 0; k < 40; k++) begin
            in_valid = (idx < 6);
            in_data  = (idx < 6) ? pay[idx] : 8'h00;
            dAck     = (k >= 5);
            if (!in_ready) full_seen = 1;
            if (in_valid && in_ready) idx++;
            else if (in_valid) refused++;
            cycle();
        end
        in_valid = 0; dAck = 0;
        check("fill_full_seen", full_seen, 1);
        check("fill_refused", refused, 3);
        check("fill_sent_n", o_sent.size(), 6);
        for (int i = 0; i < 6 && i < o_sent.size(); i++) check("fill_order", o_sent[i], i + 1);
        check("fill_err", o_err, 0);
        check("fill_hi", o_hi, 14);
        repeat (4) cycle();

        // Reset during beat 3 with two bytes queued
        clear_obs();
        in_valid = 1; in_data = 8'hC3; cycle();
        in_data = 8'h11; cycle();
        in_data = 8'h22; cycle();
        in_valid = 0; cycle();
        check("midrst_pre_dv", dValid, 1);
        check("midrst_pre_data", data, 8'hC3);
        reset = 0;
        cycle();
        check("midrst_dv", dValid, 0);
        check("midrst_data", data, 8'h00);
        check("midrst_done", tx_done, 0);
        check("midrst_err", err, 0);
        check("midrst_ready", in_ready, 0);
        reset = 1;
        clear_obs();
        repeat (8) cycle();
        check("midrst_quiet", o_hi, 0);
        check("midrst_ready_after", in_ready, 1);
        clear_obs();
        xfer(8'h5A, 4'b0010, 6);
        check("midrst_sent_n", o_sent.size(), 1);
        check("midrst_sent", o_sent.size() > 0 ? o_sent[0] : 8'hxx, 8'h5A);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'($urandom);
            dAck     = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
